// File: rtl/display_mode_sequencer_pkg.sv
// Mode encodings and advance helpers shared by the sequencer and the display mode decoder.
package display_mode_pkg;

    localparam int MODE_W = 4;
    localparam logic [MODE_W-1:0] OFF_CODE      = 4'b0000;
    localparam logic [MODE_W-1:0] XADC_RAW_CODE = 4'b0001;

    typedef enum logic [1:0] {
        SRC_XADC = 2'b00,
        SRC_PWM  = 2'b01,
        SRC_R2R  = 2'b10
    } src_t;

    typedef enum logic [1:0] {
        DATA_RAW = 2'b01,
        DATA_AVG = 2'b10,
        DATA_SCL = 2'b11
    } data_t;

    typedef enum logic [1:0] {
        ST_OFF    = 2'b00,
        ST_SETTLE = 2'b01,
        ST_ACTIVE = 2'b10
    } state_t;

    function automatic src_t next_src(input src_t s);
        case (s)
            SRC_XADC: next_src = SRC_PWM;
            SRC_PWM:  next_src = SRC_R2R;
            SRC_R2R:  next_src = SRC_XADC;
            default:  next_src = SRC_XADC;
        endcase
    endfunction

    function automatic data_t next_data(input data_t d);
        case (d)
            DATA_RAW: next_data = DATA_AVG;
            DATA_AVG: next_data = DATA_SCL;
            DATA_SCL: next_data = DATA_RAW;
            default:  next_data = DATA_RAW;
        endcase
    endfunction

    // Auto-scan order: data first, carrying into the source when data wraps.
    function automatic logic [MODE_W-1:0] adv_mode(input logic [MODE_W-1:0] m);
        src_t  s;
        data_t d;
        s = src_t'(m[3:2]);
        d = data_t'(m[1:0]);
        if (d == DATA_SCL) begin
            adv_mode = {next_src(s), DATA_RAW};
        end else begin
            adv_mode = {s, next_data(d)};
        end
    endfunction

    // Manual buttons advance their own field independently, without carry.
    function automatic logic [MODE_W-1:0] step_mode(input logic [MODE_W-1:0] m,
                                                   input logic adv_s,
                                                   input logic adv_d);
        src_t  s;
        data_t d;
        s = src_t'(m[3:2]);
        d = data_t'(m[1:0]);
        if (adv_s) begin
            s = next_src(s);
        end else begin
            s = s;
        end
        if (adv_d) begin
            d = next_data(d);
        end else begin
            d = d;
        end
        step_mode = {s, d};
    endfunction

endpackage

// File: rtl/display_mode_sequencer_if.sv
// Button/level inputs and mode outputs between the debouncers, sequencer and decoder.
interface display_mode_sequencer_if;

    logic                                 src_pulse;
    logic                                 data_pulse;
    logic                                 off_pulse;
    logic                                 auto_en;
    logic [display_mode_pkg::MODE_W-1:0]  mode_select;
    logic                                 mode_changed;
    logic                                 settle_busy;

    modport master (
        output src_pulse, data_pulse, off_pulse, auto_en,
        input  mode_select, mode_changed, settle_busy
    );

    modport slave (
        input  src_pulse, data_pulse, off_pulse, auto_en,
        output mode_select, mode_changed, settle_busy
    );

endinterface

// File: rtl/display_mode_sequencer_cycle_timer.sv
// Free-running modulo-N cycle counter with clear; done flags the last count.
module cycle_timer #(
    parameter int N = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic done
);

    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    logic [CNT_W-1:0] r_count;

    // Count while enabled, restart at zero after the last count; clear wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en) begin
            if (r_count == LAST) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + CNT_W'(1);
            end
        end else begin
            r_count <= r_count;
        end
    end

    assign done = (r_count == LAST);

endmodule

// File: rtl/display_mode_sequencer.sv
// Produces the display mode code from button pulses or the auto-scan dwell timer,
// opening a settle window after each change so downstream averagers can refill.
module display_mode_sequencer
    import display_mode_pkg::*;
#(
    parameter int DWELL_CYCLES  = 200_000_000,
    parameter int SETTLE_CYCLES = 1_000_000
) (
    input  logic                      clk,
    input  logic                      reset,
    display_mode_sequencer_if.slave   bus
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [MODE_W-1:0]   r_mode;
    logic [MODE_W-1:0]   w_mode_nxt;
    logic [MODE_W-1:0]   r_last;
    logic [MODE_W-1:0]   w_last_nxt;
    logic [MODE_W-1:0]   w_manual_mode;
    logic                r_changed;
    logic                w_changed_nxt;
    logic                r_busy;
    logic                w_manual;
    logic                w_settle_clr;
    logic                w_settle_en;
    logic                w_settle_done;
    logic                w_dwell_clr;
    logic                w_dwell_en;
    logic                w_dwell_done;

    assign w_manual      = bus.src_pulse | bus.data_pulse;
    assign w_manual_mode = step_mode(r_mode, bus.src_pulse, bus.data_pulse);

    assign w_settle_en   = (r_state == ST_SETTLE);
    assign w_dwell_en    = (r_state == ST_ACTIVE) & bus.auto_en;
    // Any manual input or auto_en low restarts the dwell from zero.
    assign w_dwell_clr   = ~w_dwell_en | w_manual | bus.off_pulse;

    cycle_timer #(.N(SETTLE_CYCLES)) u_settle_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (w_settle_clr),
        .en    (w_settle_en),
        .done  (w_settle_done)
    );

    cycle_timer #(.N(DWELL_CYCLES)) u_dwell_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (w_dwell_clr),
        .en    (w_dwell_en),
        .done  (w_dwell_done)
    );

    // Next-state and next-mode selection; off_pulse outranks manual, manual outranks timers.
    always_comb begin
        w_state_nxt   = r_state;
        w_mode_nxt    = r_mode;
        w_last_nxt    = r_last;
        w_changed_nxt = 1'b0;
        w_settle_clr  = 1'b0;
        case (r_state)
            ST_OFF: begin
                if (bus.off_pulse) begin
                    w_state_nxt   = ST_SETTLE;
                    w_mode_nxt    = r_last;
                    w_changed_nxt = 1'b1;
                    w_settle_clr  = 1'b1;
                end else begin
                    w_state_nxt   = ST_OFF;
                end
            end
            ST_SETTLE, ST_ACTIVE: begin
                if (bus.off_pulse) begin
                    w_state_nxt   = ST_OFF;
                    w_last_nxt    = r_mode;
                    w_mode_nxt    = OFF_CODE;
                    w_changed_nxt = 1'b1;
                end else if (w_manual) begin
                    w_state_nxt   = ST_SETTLE;
                    w_mode_nxt    = w_manual_mode;
                    w_changed_nxt = 1'b1;
                    w_settle_clr  = 1'b1;
                end else if (r_state == ST_SETTLE) begin
                    if (w_settle_done) begin
                        w_state_nxt = ST_ACTIVE;
                    end else begin
                        w_state_nxt = ST_SETTLE;
                    end
                end else if (bus.auto_en && w_dwell_done) begin
                    w_state_nxt   = ST_SETTLE;
                    w_mode_nxt    = adv_mode(r_mode);
                    w_changed_nxt = 1'b1;
                    w_settle_clr  = 1'b1;
                end else begin
                    w_state_nxt   = ST_ACTIVE;
                end
            end
            default: begin
                w_state_nxt   = ST_OFF;
                w_mode_nxt    = OFF_CODE;
                w_last_nxt    = XADC_RAW_CODE;
                w_changed_nxt = 1'b1;
            end
        endcase
    end

    // State, mode memory and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_OFF;
            r_mode    <= OFF_CODE;
            r_last    <= XADC_RAW_CODE;
            r_changed <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_mode    <= w_mode_nxt;
            r_last    <= w_last_nxt;
            r_changed <= w_changed_nxt;
            r_busy    <= (w_state_nxt == ST_SETTLE);
        end
    end

    assign bus.mode_select  = r_mode;
    assign bus.mode_changed = r_changed;
    assign bus.settle_busy  = r_busy;

endmodule

// File: tb/tb_display_mode_sequencer.sv
// Randomized scoreboard bench for display_mode_sequencer with an index-based reference model.
module tb_display_mode_sequencer;

    localparam int SETTLE = 4;
    localparam int DWELL  = 8;

    logic clk = 1'b0;
    logic reset;

    display_mode_sequencer_if bus();

    display_mode_sequencer #(
        .DWELL_CYCLES  (DWELL),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] mode;
        logic       busy;
        logic       chg;
    } cyc_exp_t;

    typedef struct {
        int         cyc;
        logic [3:0] mode;
    } chg_exp_t;

    cyc_exp_t cyc_q[$];
    chg_exp_t chg_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    bit cur_auto = 1'b0;

    // Reference model: source index 0..2 (XADC,PWM,R2R), data index 0..2 (RAW,AVG,SCL).
    bit m_on         = 1'b0;
    int m_src        = 0;
    int m_dat        = 0;
    int m_lsrc       = 0;
    int m_ldat       = 0;
    int m_settle_left = 0;
    int m_dwell      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] code_of(input int s, input int d);
        logic [1:0] sb;
        logic [1:0] db;
        sb = 2'(s);
        db = 2'(d + 1);
        return {sb, db};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    function automatic void model_step(input bit rs, input bit s, input bit d, input bit o, input bit a);
        bit chg;
        logic [3:0] m;
        chg = 1'b0;
        if (rs) begin
            m_on = 1'b0; m_lsrc = 0; m_ldat = 0; m_settle_left = 0; m_dwell = 0;
        end else if (!m_on) begin
            if (o) begin
                m_on = 1'b1; m_src = m_lsrc; m_dat = m_ldat;
                m_settle_left = SETTLE; m_dwell = 0; chg = 1'b1;
            end
        end else if (o) begin
            m_lsrc = m_src; m_ldat = m_dat; m_on = 1'b0;
            m_settle_left = 0; m_dwell = 0; chg = 1'b1;
        end else if (s || d) begin
            if (s) m_src = (m_src + 1) % 3;
            if (d) m_dat = (m_dat + 1) % 3;
            m_settle_left = SETTLE; m_dwell = 0; chg = 1'b1;
        end else if (m_settle_left > 0) begin
            m_settle_left--; m_dwell = 0;
        end else if (a) begin
            m_dwell++;
            if (m_dwell == DWELL) begin
                m_dat = (m_dat + 1) % 3;
                if (m_dat == 0) m_src = (m_src + 1) % 3;
                m_settle_left = SETTLE; m_dwell = 0; chg = 1'b1;
            end
        end else begin
            m_dwell = 0;
        end
        m = m_on ? code_of(m_src, m_dat) : 4'b0000;
        cyc_q.push_back('{mode: m, busy: (m_settle_left > 0), chg: chg});
        if (chg) chg_q.push_back('{cyc: cyc + 1, mode: m});
    endfunction

    task automatic step(input bit rs, input bit s, input bit d, input bit o);
        @(negedge clk);
        reset          = rs;
        bus.src_pulse  = s;
        bus.data_pulse = d;
        bus.off_pulse  = o;
        bus.auto_en    = cur_auto;
        model_step(rs, s, d, o, cur_auto);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic peek(input string name, input logic [3:0] exp_mode);
        @(posedge clk);
        #3;
        check(name, 32'(bus.mode_select), 32'(exp_mode));
    endtask

    // Monitor: per-cycle outputs against the model, change strobes against the change queue.
    initial begin
        cyc_exp_t e;
        chg_exp_t ce;
        forever begin
            @(posedge clk);
            #2;
            if (cyc_q.size() > 0) begin
                e = cyc_q.pop_front();
                check("mode_select", 32'(bus.mode_select), 32'(e.mode));
                check("settle_busy", 32'(bus.settle_busy), 32'(e.busy));
                check("mode_changed", 32'(bus.mode_changed), 32'(e.chg));
            end
            if (bus.mode_changed === 1'b1) begin
                if (chg_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL chg_unexpected: mode_changed=1 with mode %0h, none expected (cycle %0d)",
                             bus.mode_select, cyc);
                end else begin
                    ce = chg_q.pop_front();
                    check("chg_cycle", 32'(cyc), 32'(ce.cyc));
                    check("chg_mode", 32'(bus.mode_select), 32'(ce.mode));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; bus.src_pulse = 1'b0; bus.data_pulse = 1'b0;
        bus.off_pulse = 1'b0; bus.auto_en = 1'b0;

        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        peek("reset_mode", 4'b0000);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        peek("on_from_reset", 4'b0001);
        idle(12);

        step(1'b0, 1'b1, 1'b0, 1'b0); peek("src_1", 4'b0101); idle(9);
        step(1'b0, 1'b1, 1'b0, 1'b0); peek("src_2", 4'b1001); idle(9);
        step(1'b0, 1'b1, 1'b0, 1'b0); peek("src_3", 4'b0001); idle(9);
        step(1'b0, 1'b0, 1'b0, 1'b1); peek("off", 4'b0000);
        step(1'b0, 1'b1, 1'b0, 1'b0); peek("src_in_off", 4'b0000);
        step(1'b0, 1'b0, 1'b0, 1'b1); peek("restore_1", 4'b0001); idle(6);

        step(1'b0, 1'b1, 1'b0, 1'b0); idle(5);
        step(1'b0, 1'b0, 1'b1, 1'b0); idle(5);
        step(1'b0, 1'b0, 1'b1, 1'b0); peek("pwm_scl", 4'b0111); idle(5);
        step(1'b0, 1'b1, 1'b1, 1'b0); peek("src_data_same", 4'b1001); idle(5);
        step(1'b0, 1'b0, 1'b1, 1'b1); peek("off_overrides", 4'b0000); idle(3);
        step(1'b0, 1'b0, 1'b0, 1'b1); peek("restore_2", 4'b1001); idle(6);

        cur_auto = 1'b1;
        idle(9 * (SETTLE + DWELL) + 6);
        cur_auto = 1'b0;
        idle(8);

        step(1'b0, 1'b0, 1'b1, 1'b0); idle(2);
        step(1'b0, 1'b0, 1'b1, 1'b0); idle(6);
        step(1'b0, 1'b1, 1'b0, 1'b0); idle(1);
        step(1'b1, 1'b0, 1'b0, 1'b0); peek("reset_mid_settle", 4'b0000); idle(2);
        step(1'b0, 1'b0, 1'b0, 1'b1); peek("last_after_reset", 4'b0001); idle(6);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) cur_auto = ~cur_auto;
            step($urandom_range(0, 599) == 0,
                 $urandom_range(0, 29) == 0,
                 $urandom_range(0, 29) == 0,
                 $urandom_range(0, 49) == 0);
        end

        idle(2);
        @(posedge clk);
        #4;
        check("cyc_q_drained", 32'(cyc_q.size()), 32'd0);
        check("chg_q_drained", 32'(chg_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
